// File: rtl/led_panel_capture.sv
// LED panel capture: decodes a 1/4-scan panel's shift, latch and row-address
// signals into a 2-half x 4-row x 32-column RGB frame store with a registered read port.
module led_panel_capture (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       red_in,
  input  logic       green_in,
  input  logic       blue_in,
  input  logic       sclk_in,
  input  logic       latch_in,
  input  logic       blank_in,
  input  logic       aclk_in,
  input  logic       arst_in,
  input  logic       rd_half,
  input  logic [1:0] rd_row,
  input  logic [4:0] rd_col,
  output logic [2:0] rd_rgb,
  output logic [1:0] row_addr,
  output logic       lit,
  output logic       row_done,
  output logic       frame_done,
  output logic       col_err
);

  logic        sclk_prev_q, latch_prev_q, aclk_prev_q;
  logic        sclk_rise, sclk_fall, latch_rise, aclk_rise;
  logic [2:0]  pix_in;

  // Index 2 = red, 1 = green, 0 = blue; bit c of each register is column c.
  logic [31:0] sr_up_q [3];
  logic [31:0] sr_up_d [3];
  logic [31:0] sr_lo_q [3];
  logic [31:0] sr_lo_d [3];

  logic [5:0]  edge_cnt_q, edge_cnt_d;
  logic [1:0]  row_addr_q, row_addr_d;
  logic        row_done_q, row_done_d;
  logic        frame_done_q, frame_done_d;
  logic        col_err_q, col_err_d;
  logic        lit_q, lit_d;

  // Half 0 is the upper half (captured on sclk rise), half 1 the lower (sclk fall).
  logic [2:0]  mem_q [2][4][32];
  logic [2:0]  rd_rgb_q;

  always_comb begin
    pix_in     = {red_in, green_in, blue_in};
    sclk_rise  = ~sclk_prev_q & sclk_in;
    sclk_fall  = sclk_prev_q & ~sclk_in;
    latch_rise = ~latch_prev_q & latch_in;
    aclk_rise  = ~aclk_prev_q & aclk_in;
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      sr_up_d[k] = sr_up_q[k];
      sr_lo_d[k] = sr_lo_q[k];
      if (sclk_rise) sr_up_d[k] = {sr_up_q[k][30:0], pix_in[k]};
      if (sclk_fall) sr_lo_d[k] = {sr_lo_q[k][30:0], pix_in[k]};
    end

    edge_cnt_d = edge_cnt_q;
    if (latch_rise)
      edge_cnt_d = 6'd0;
    else if (sclk_rise && (edge_cnt_q != 6'd63))
      edge_cnt_d = edge_cnt_q + 6'd1;

    // Row reset dominates an address-advance edge in the same cycle.
    row_addr_d = row_addr_q;
    if (arst_in)
      row_addr_d = 2'd0;
    else if (aclk_rise)
      row_addr_d = row_addr_q + 2'd1;

    row_done_d   = latch_rise;
    frame_done_d = latch_rise && (row_addr_q == 2'd3);
    col_err_d    = col_err_q | (latch_rise && (edge_cnt_q != 6'd32));
    lit_d        = ~blank_in;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sclk_prev_q  <= 1'b1;
      latch_prev_q <= 1'b0;
      aclk_prev_q  <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        sr_up_q[k] <= '0;
        sr_lo_q[k] <= '0;
      end
      edge_cnt_q   <= '0;
      row_addr_q   <= '0;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      col_err_q    <= 1'b0;
      lit_q        <= 1'b0;
    end else begin
      sclk_prev_q  <= sclk_in;
      latch_prev_q <= latch_in;
      aclk_prev_q  <= aclk_in;
      for (int k = 0; k < 3; k++) begin
        sr_up_q[k] <= sr_up_d[k];
        sr_lo_q[k] <= sr_lo_d[k];
      end
      edge_cnt_q   <= edge_cnt_d;
      row_addr_q   <= row_addr_d;
      row_done_q   <= row_done_d;
      frame_done_q <= frame_done_d;
      col_err_q    <= col_err_d;
      lit_q        <= lit_d;
    end
  end

  // The read samples mem_q before this cycle's latch commits, so a colliding read sees old data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_rgb_q <= '0;
      for (int h = 0; h < 2; h++)
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 32; c++)
            mem_q[h][r][c] <= '0;
    end else begin
      rd_rgb_q <= mem_q[rd_half][rd_row][rd_col];
      if (latch_rise) begin
        for (int c = 0; c < 32; c++) begin
          mem_q[0][row_addr_q][c] <= {sr_up_q[2][c], sr_up_q[1][c], sr_up_q[0][c]};
          mem_q[1][row_addr_q][c] <= {sr_lo_q[2][c], sr_lo_q[1][c], sr_lo_q[0][c]};
        end
      end
    end
  end

  assign rd_rgb     = rd_rgb_q;
  assign row_addr   = row_addr_q;
  assign lit        = lit_q;
  assign row_done   = row_done_q;
  assign frame_done = frame_done_q;
  assign col_err    = col_err_q;

endmodule

// File: tb/tb_led_panel_capture.sv
// Directed bench for led_panel_capture: a behavioural panel model predicts frame contents,
// expected read data goes through a scoreboard queue and is compared when rd_rgb is valid.
module tb_led_panel_capture;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       red_in, green_in, blue_in;
  logic       sclk_in, latch_in, blank_in, aclk_in, arst_in;
  logic       rd_half;
  logic [1:0] rd_row;
  logic [4:0] rd_col;
  logic [2:0] rd_rgb;
  logic [1:0] row_addr;
  logic       lit, row_done, frame_done, col_err;

  int passCount  = 0;
  int checkCount = 0;
  int failCount  = 0;

  // Bench-side model of the panel: shift registers, frame store, row pointer, error flag.
  logic [31:0] mUp [3];
  logic [31:0] mLo [3];
  logic [2:0]  expMem [2][4][32];
  logic [2:0]  expQ [$];
  int          expRow;
  int          pairCount;
  logic        expErr;

  led_panel_capture dut (
    .clk(clk), .reset_n(reset_n),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .sclk_in(sclk_in), .latch_in(latch_in), .blank_in(blank_in),
    .aclk_in(aclk_in), .arst_in(arst_in),
    .rd_half(rd_half), .rd_row(rd_row), .rd_col(rd_col),
    .rd_rgb(rd_rgb), .row_addr(row_addr), .lit(lit),
    .row_done(row_done), .frame_done(frame_done), .col_err(col_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checkCount++;
    assert (obs === expv) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [2:0] getPix(input int kind, input int half, input int col);
    if (kind == 0) begin
      if (half == 1) return (col < 8) ? 3'b001 : 3'b000;
      return (col >= 8 && col < 16) ? 3'b100 : 3'b000;
    end
    return 3'((col * 3 + half * 5 + kind * 7) ^ (col >> 2));
  endfunction

  task automatic clearModel();
    for (int k = 0; k < 3; k++) begin
      mUp[k] = '0;
      mLo[k] = '0;
    end
    for (int h = 0; h < 2; h++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 32; c++)
          expMem[h][r][c] = '0;
    expRow    = 0;
    pairCount = 0;
    expErr    = 1'b0;
  endtask

  // One sclk fall (lower-half data) followed by one sclk rise (upper-half data).
  task automatic applyStimulus(input logic [2:0] upper, input logic [2:0] lower);
    sclk_in = 1'b0;
    {red_in, green_in, blue_in} = lower;
    for (int k = 0; k < 3; k++) mLo[k] = {mLo[k][30:0], lower[k]};
    tick();
    sclk_in = 1'b1;
    {red_in, green_in, blue_in} = upper;
    for (int k = 0; k < 3; k++) mUp[k] = {mUp[k][30:0], upper[k]};
    pairCount++;
    tick();
  endtask

  task automatic writeRow(input int kind, input int nPairs);
    for (int i = 0; i < nPairs; i++) begin
      int col;
      col = (31 - i) & 31;
      applyStimulus(getPix(kind, 0, col), getPix(kind, 1, col));
    end
    {red_in, green_in, blue_in} = 3'b000;
  endtask

  task automatic readCheck(input string tag, input int half, input int row, input int col,
                           input logic useConst, input logic [2:0] constVal);
    rd_half = half[0];
    rd_row  = row[1:0];
    rd_col  = col[4:0];
    expQ.push_back(useConst ? constVal : expMem[half][row][col]);
    tick();
    checkOutput(tag, rd_rgb, expQ.pop_front());
  endtask

  task automatic readAll(input string tag);
    for (int h = 0; h < 2; h++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 32; c++)
          readCheck(tag, h, r, c, 1'b0, 3'b000);
  endtask

  // Latch the shifted row; the read issued in the latch cycle must return pre-write data.
  task automatic latchRow(input logic withAclk);
    int   row;
    logic frameExp, errNow;
    row      = expRow;
    frameExp = (row == 3);
    errNow   = expErr | (pairCount != 32);
    rd_half  = 1'b0;
    rd_row   = row[1:0];
    rd_col   = 5'd10;
    expQ.push_back(expMem[0][row][10]);
    latch_in = 1'b1;
    if (withAclk) aclk_in = 1'b1;
    tick();
    checkOutput("latch_old_read", rd_rgb, expQ.pop_front());
    checkOutput("row_done_pulse", row_done, 1'b1);
    checkOutput("frame_done_at_latch", frame_done, frameExp);
    checkOutput("col_err_at_latch", col_err, errNow);
    for (int c = 0; c < 32; c++) begin
      expMem[0][row][c] = {mUp[2][c], mUp[1][c], mUp[0][c]};
      expMem[1][row][c] = {mLo[2][c], mLo[1][c], mLo[0][c]};
    end
    expErr    = errNow;
    pairCount = 0;
    if (withAclk) expRow = (expRow + 1) % 4;
    checkOutput("row_addr_after_latch", row_addr, expRow[1:0]);
    latch_in = 1'b0;
    aclk_in  = 1'b0;
    expQ.push_back(expMem[0][row][10]);
    tick();
    checkOutput("latch_new_read", rd_rgb, expQ.pop_front());
    checkOutput("row_done_clear", row_done, 1'b0);
    checkOutput("frame_done_clear", frame_done, 1'b0);
  endtask

  task automatic aclkPulse();
    aclk_in = 1'b1;
    tick();
    expRow = (expRow + 1) % 4;
    checkOutput("row_addr_advance", row_addr, expRow[1:0]);
    aclk_in = 1'b0;
    tick();
    checkOutput("row_addr_hold", row_addr, expRow[1:0]);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_rd_rgb"}, rd_rgb, 3'b000);
    checkOutput({tag, "_row_addr"}, row_addr, 2'd0);
    checkOutput({tag, "_lit"}, lit, 1'b0);
    checkOutput({tag, "_row_done"}, row_done, 1'b0);
    checkOutput({tag, "_frame_done"}, frame_done, 1'b0);
    checkOutput({tag, "_col_err"}, col_err, 1'b0);
  endtask

  initial begin
    reset_n  = 1'b0;
    {red_in, green_in, blue_in} = 3'b000;
    sclk_in  = 1'b1;
    latch_in = 1'b0;
    blank_in = 1'b1;
    aclk_in  = 1'b0;
    arst_in  = 1'b0;
    rd_half  = 1'b0;
    rd_row   = 2'd0;
    rd_col   = 5'd0;
    clearModel();

    // Power-on reset and an empty frame store.
    tick();
    tick();
    checkResetState("por");
    reset_n = 1'b1;
    readAll("por_read");

    // lit follows blank_in inverted, one cycle late.
    blank_in = 1'b0;
    tick();
    checkOutput("lit_on", lit, 1'b1);
    blank_in = 1'b1;
    tick();
    checkOutput("lit_off", lit, 1'b0);

    // Single row write into row 0 with a known pattern.
    arst_in = 1'b1;
    tick();
    expRow = 0;
    arst_in = 1'b0;
    checkOutput("arst_row0", row_addr, 2'd0);
    writeRow(0, 32);
    latchRow(1'b0);
    readCheck("row0_half1_col3", 1, 0, 3, 1'b1, 3'b001);
    readCheck("row0_half0_col10", 0, 0, 10, 1'b1, 3'b100);
    readCheck("row0_half0_col3", 0, 0, 3, 1'b1, 3'b000);
    readCheck("row0_half1_col10", 1, 0, 10, 1'b1, 3'b000);

    // Remaining rows of the frame; frame_done only on the row-3 latch, then wrap.
    for (int r = 1; r < 4; r++) begin
      aclkPulse();
      writeRow(r, 32);
      latchRow(1'b0);
    end
    aclkPulse();
    checkOutput("row_addr_wrap", row_addr, 2'd0);
    readAll("frame_read");

    // Latch and aclk edges together at row 1: data lands in row 1, pointer moves to 2.
    aclkPulse();
    writeRow(5, 32);
    latchRow(1'b1);
    checkOutput("collision_row_addr", row_addr, 2'd2);
    readCheck("collision_row1_a", 1, 1, 0, 1'b0, 3'b000);
    readCheck("collision_row1_b", 0, 1, 31, 1'b0, 3'b000);
    readCheck("collision_row2_untouched", 0, 2, 5, 1'b0, 3'b000);

    // arst beats a simultaneous aclk edge.
    arst_in = 1'b1;
    aclk_in = 1'b1;
    tick();
    expRow = 0;
    checkOutput("arst_priority", row_addr, 2'd0);
    arst_in = 1'b0;
    aclk_in = 1'b0;
    tick();
    checkOutput("arst_priority_hold", row_addr, 2'd0);

    // Short row sets col_err, and a following good row does not clear it.
    writeRow(6, 31);
    latchRow(1'b0);
    checkOutput("miscount_err", col_err, 1'b1);
    writeRow(7, 32);
    latchRow(1'b0);
    checkOutput("err_sticky", col_err, 1'b1);
    readCheck("miscount_row0", 1, 0, 31, 1'b0, 3'b000);

    // Reset in the middle of a row wipes everything.
    blank_in = 1'b0;
    tick();
    checkOutput("lit_before_reset", lit, 1'b1);
    writeRow(8, 10);
    reset_n = 1'b0;
    tick();
    clearModel();
    checkResetState("midrow");
    reset_n  = 1'b1;
    blank_in = 1'b1;
    readAll("midrow_read");

    // Exactly 32 edges after reset is a clean row; 96 edges must not alias back to 32.
    writeRow(9, 32);
    latchRow(1'b0);
    checkOutput("post_reset_clean", col_err, 1'b0);
    writeRow(10, 96);
    latchRow(1'b0);
    checkOutput("saturate_err", col_err, 1'b1);
    readAll("final_read");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
